instr_fetch: RTL and testbench

Instruction-fetch stage of the five-stage MIPS pipeline, directly upstream of the decode stage. It owns the program counter, issues one instruction-memory read at a time over a valid/ready request and response interface, and loads the IF/ID pipeline register. It absorbs decode stalls with a one-entry hold buffer and applies branch and jump redirects resolved in decode. Wrong-path responses still in flight are discarded.

---
 rtl/fetch_pkg.sv | 28 ++
 rtl/if_id_reg.sv | 41 ++++
 rtl/instr_fetch.sv | 137 +++++++++++++
 tb/tb_instr_fetch.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned XLEN = 32;

    localparam logic [XLEN-1:0] RESET_PC  = 32'h0000_0000;
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0000;
    localparam logic [XLEN-1:0] PC_STEP   = 32'd4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        HELD = 2'd2,
        DROP = 2'd3
    } fetch_state_t;

    // Instruction word paired with the address of the following instruction.
    typedef struct packed {
        logic [XLEN-1:0] instr;
        logic [XLEN-1:0] pc_plus_4;
    } fetch_word_t;

    // Sequential fetch address; wraps at 2^32, low bits pass through.
    function automatic logic [XLEN-1:0] next_pc(input logic [XLEN-1:0] pc);
        return XLEN'(pc + PC_STEP);
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: bubble beats hold beats load; idle cycles insert a bubble.
module if_id_reg
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            flush,
    input  logic            stall,
    input  logic            load,
    input  fetch_word_t     word,
    output logic [XLEN-1:0] instr,
    output logic [XLEN-1:0] pc_plus_4,
    output logic            valid
);

    // Register update with flush > stall > load > bubble priority.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            instr     <= NOP_INSTR;
            pc_plus_4 <= '0;
            valid     <= 1'b0;
        end else if (flush) begin
            instr     <= NOP_INSTR;
            pc_plus_4 <= '0;
            valid     <= 1'b0;
        end else if (stall) begin
            instr     <= instr;
            pc_plus_4 <= pc_plus_4;
            valid     <= valid;
        end else if (load) begin
            instr     <= word.instr;
            pc_plus_4 <= word.pc_plus_4;
            valid     <= 1'b1;
        end else begin
            instr     <= NOP_INSTR;
            pc_plus_4 <= '0;
            valid     <= 1'b0;
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction-fetch stage: PC, single-outstanding imem read, stall hold buffer, redirects.
module instr_fetch
    import fetch_pkg::*;
(
    input  logic            clk,
    input  logic            reset_n,
    input  logic            stall_id,
    input  logic            flush_id,
    input  logic            id_pc_src,
    input  logic            id_jump,
    input  logic [XLEN-1:0] id_pc_branch,
    input  logic [XLEN-1:0] id_pc_jump,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic [XLEN-1:0] if_id_instr,
    output logic [XLEN-1:0] if_id_pc_plus_4,
    output logic            if_id_valid
);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] inflight_pc4_q, inflight_pc4_d;
    fetch_word_t     hold_q, hold_d;
    logic            req_valid_q;

    logic            redirect;
    logic [XLEN-1:0] redirect_target;
    logic            req_fire;
    logic            ifid_load;
    fetch_word_t     ifid_word;

    // Decode-stage redirect; jump wins over branch, ignored while decode is stalled.
    assign redirect        = (id_pc_src | id_jump) & ~stall_id;
    assign redirect_target = id_jump ? id_pc_jump : id_pc_branch;
    assign req_fire        = req_valid_q & imem_req_ready;

    assign imem_req_valid  = req_valid_q;
    assign imem_addr       = pc_q;

    // State and datapath registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            pc_q           <= RESET_PC;
            inflight_pc4_q <= '0;
            hold_q         <= '0;
            req_valid_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            pc_q           <= pc_d;
            inflight_pc4_q <= inflight_pc4_d;
            hold_q         <= hold_d;
            req_valid_q    <= (state_d == IDLE);
        end
    end

    // Next-state, PC and IF/ID load selection.
    always_comb begin
        state_d        = state_q;
        pc_d           = pc_q;
        inflight_pc4_d = inflight_pc4_q;
        hold_d         = hold_q;
        ifid_load      = 1'b0;
        ifid_word      = '0;

        case (state_q)
            IDLE: begin
                // Responses seen here are protocol errors or pre-reset leftovers.
                if (req_fire) begin
                    pc_d           = next_pc(pc_q);
                    inflight_pc4_d = next_pc(pc_q);
                    state_d        = WAIT;
                end
            end
            WAIT: begin
                if (imem_rsp_valid) begin
                    if (stall_id || flush_id) begin
                        hold_d.instr     = imem_rsp_data;
                        hold_d.pc_plus_4 = inflight_pc4_q;
                        state_d          = HELD;
                    end else begin
                        ifid_load           = 1'b1;
                        ifid_word.instr     = imem_rsp_data;
                        ifid_word.pc_plus_4 = inflight_pc4_q;
                        state_d             = IDLE;
                    end
                end
            end
            HELD: begin
                if (!stall_id && !flush_id) begin
                    ifid_load = 1'b1;
                    ifid_word = hold_q;
                    hold_d    = '0;
                    state_d   = IDLE;
                end
            end
            DROP: begin
                if (imem_rsp_valid) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Redirect overrides: a response landing this cycle is the stale one.
        if (redirect) begin
            pc_d      = redirect_target;
            hold_d    = '0;
            ifid_load = 1'b0;
            case (state_q)
                IDLE:    state_d = req_fire ? DROP : IDLE;
                WAIT:    state_d = imem_rsp_valid ? IDLE : DROP;
                HELD:    state_d = IDLE;
                DROP:    state_d = imem_rsp_valid ? IDLE : DROP;
                default: state_d = IDLE;
            endcase
        end
    end

    if_id_reg u_if_id_reg (
        .clk       (clk),
        .reset_n   (reset_n),
        .flush     (flush_id | redirect),
        .stall     (stall_id),
        .load      (ifid_load),
        .word      (ifid_word),
        .instr     (if_id_instr),
        .pc_plus_4 (if_id_pc_plus_4),
        .valid     (if_id_valid)
    );

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with request and IF/ID scoreboards.
module tb_instr_fetch;

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc4;
    } ifid_exp_t;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall_id, flush_id, id_pc_src, id_jump;
    logic [31:0] id_pc_branch, id_pc_jump;
    logic        imem_req_valid, imem_req_ready;
    logic [31:0] imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic [31:0] if_id_instr, if_id_pc_plus_4;
    logic        if_id_valid;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_req[$];
    ifid_exp_t   exp_ifid[$];
    logic        held_q = 1'b0;

    instr_fetch dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .stall_id        (stall_id),
        .flush_id        (flush_id),
        .id_pc_src       (id_pc_src),
        .id_jump         (id_jump),
        .id_pc_branch    (id_pc_branch),
        .id_pc_jump      (id_pc_jump),
        .imem_req_valid  (imem_req_valid),
        .imem_req_ready  (imem_req_ready),
        .imem_addr       (imem_addr),
        .imem_rsp_valid  (imem_rsp_valid),
        .imem_rsp_data   (imem_rsp_data),
        .if_id_instr     (if_id_instr),
        .if_id_pc_plus_4 (if_id_pc_plus_4),
        .if_id_valid     (if_id_valid)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic at_neg();
        @(negedge clk);
    endtask

    task automatic push_ifid(input logic [31:0] instr, input logic [31:0] pc4);
        ifid_exp_t e;
        e.instr = instr;
        e.pc4   = pc4;
        exp_ifid.push_back(e);
    endtask

    // Stall at the last edge means IF/ID contents were held, not freshly loaded.
    always @(posedge clk) held_q <= stall_id;

    // Monitor: pops expectations whenever the DUT handshakes a request or loads IF/ID.
    always @(negedge clk) begin
        if (reset_n && imem_req_valid && imem_req_ready) begin
            if (exp_req.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_req: got addr %h expected none", imem_addr);
            end else begin
                chk("req_addr", imem_addr, exp_req.pop_front());
            end
        end
        if (if_id_valid && !held_q) begin
            if (exp_ifid.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_ifid: got %h/%h expected bubble", if_id_instr, if_id_pc_plus_4);
            end else begin
                ifid_exp_t e;
                e = exp_ifid.pop_front();
                chk("ifid_instr", if_id_instr, e.instr);
                chk("ifid_pc4", if_id_pc_plus_4, e.pc4);
            end
        end
    end

    // One complete fetch from IDLE at a zero-wait memory.
    task automatic fetch(input logic [31:0] addr, input logic [31:0] data);
        imem_req_ready = 1'b1;
        exp_req.push_back(addr);
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = data;
        push_ifid(data, addr + 32'd4);
        tick();
        imem_rsp_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        reset_n = 1'b0;
        stall_id = 1'b0; flush_id = 1'b0; id_pc_src = 1'b0; id_jump = 1'b0;
        id_pc_branch = '0; id_pc_jump = '0;
        imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rsp_data = '0;

        // Reset state
        repeat (2) tick();
        at_neg();
        chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_ifid_valid", 32'(if_id_valid), 32'd0);
        chk("rst_ifid_instr", if_id_instr, 32'h0);
        chk("rst_ifid_pc4", if_id_pc_plus_4, 32'h0);
        reset_n = 1'b1;
        tick();
        at_neg();
        chk("post_rst_req_valid", 32'(imem_req_valid), 32'd1);

        // Basic fetch at 0, zero-wait memory
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h0);
        tick();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h2008_0005;
        push_ifid(32'h2008_0005, 32'h4);
        at_neg();
        chk("wait_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        imem_rsp_valid = 1'b0;
        at_neg();
        chk("t1_req_valid", 32'(imem_req_valid), 32'd1);
        chk("t1_next_addr", imem_addr, 32'h4);

        // Response during a 3-cycle decode stall goes through the hold buffer
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h4);
        tick();
        imem_req_ready = 1'b0;
        stall_id = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h8C02_0010;
        tick();
        imem_rsp_valid = 1'b0;
        imem_req_ready = 1'b1;
        at_neg();
        chk("held_no_req1", 32'(imem_req_valid), 32'd0);
        tick();
        at_neg();
        chk("held_no_req2", 32'(imem_req_valid), 32'd0);
        tick();
        imem_req_ready = 1'b0;
        stall_id = 1'b0;
        push_ifid(32'h8C02_0010, 32'h8);
        at_neg();
        chk("held_ifid_bubble", 32'(if_id_valid), 32'd0);
        tick();
        at_neg();
        chk("t2_next_addr", imem_addr, 32'h8);

        // Taken branch while WAIT: stale response dropped
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h8);
        tick();
        imem_req_ready = 1'b0;
        id_pc_src = 1'b1;
        id_pc_branch = 32'h40;
        tick();
        id_pc_src = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_BEEF;
        at_neg();
        chk("drop_req_valid", 32'(imem_req_valid), 32'd0);
        chk("drop_addr", imem_addr, 32'h40);
        tick();
        imem_rsp_valid = 1'b0;
        at_neg();
        chk("drop_ifid_valid", 32'(if_id_valid), 32'd0);
        chk("t3_next_addr", imem_addr, 32'h40);
        fetch(32'h40, 32'h1000_FFFF);

        // Branch with response in the same cycle: WAIT goes straight to IDLE
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h44);
        tick();
        imem_req_ready = 1'b0;
        id_pc_src = 1'b1;
        id_pc_branch = 32'h200;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hBAD0_0001;
        tick();
        id_pc_src = 1'b0;
        imem_rsp_valid = 1'b0;
        at_neg();
        chk("redir_rsp_req_valid", 32'(imem_req_valid), 32'd1);
        chk("redir_rsp_addr", imem_addr, 32'h200);

        // Jump and branch together: jump wins
        id_jump = 1'b1; id_pc_src = 1'b1;
        id_pc_jump = 32'h100; id_pc_branch = 32'h80;
        tick();
        id_jump = 1'b0; id_pc_src = 1'b0;
        at_neg();
        chk("jump_prio_addr", imem_addr, 32'h100);
        fetch(32'h100, 32'h0800_0040);

        // Redirect coinciding with a handshake in IDLE: DROP
        imem_req_ready = 1'b1;
        id_pc_src = 1'b1;
        id_pc_branch = 32'h300;
        exp_req.push_back(32'h104);
        tick();
        imem_req_ready = 1'b0;
        id_pc_src = 1'b0;
        at_neg();
        chk("idle_drop_req_valid", 32'(imem_req_valid), 32'd0);
        chk("idle_drop_addr", imem_addr, 32'h300);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'hDEAD_0002;
        tick();
        imem_rsp_valid = 1'b0;

        // Memory not ready for 4 cycles
        for (int i = 0; i < 4; i++) begin
            at_neg();
            chk("notrdy_req_valid", 32'(imem_req_valid), 32'd1);
            chk("notrdy_addr", imem_addr, 32'h300);
            chk("notrdy_ifid_valid", 32'(if_id_valid), 32'd0);
            tick();
        end
        fetch(32'h300, 32'h2129_0001);

        // Flush with a response in WAIT: data parks in the hold buffer
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h304);
        tick();
        imem_req_ready = 1'b0;
        flush_id = 1'b1;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h0109_5020;
        tick();
        flush_id = 1'b0;
        imem_rsp_valid = 1'b0;
        push_ifid(32'h0109_5020, 32'h308);
        at_neg();
        chk("flush_held_req_valid", 32'(imem_req_valid), 32'd0);
        tick();
        at_neg();
        chk("flush_next_addr", imem_addr, 32'h308);

        // Wrap-around at the top of the address space
        id_pc_src = 1'b1;
        id_pc_branch = 32'hFFFF_FFFC;
        tick();
        id_pc_src = 1'b0;
        fetch(32'hFFFF_FFFC, 32'h3C01_1234);
        at_neg();
        chk("wrap_next_addr", imem_addr, 32'h0);

        // Reset mid-WAIT with a valid, stalled IF/ID
        fetch(32'h0, 32'h2402_000A);
        stall_id = 1'b1;
        imem_req_ready = 1'b1;
        exp_req.push_back(32'h4);
        tick();
        imem_req_ready = 1'b0;
        at_neg();
        chk("pre_rst_ifid_valid", 32'(if_id_valid), 32'd1);
        chk("pre_rst_req_valid", 32'(imem_req_valid), 32'd0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_req_valid", 32'(imem_req_valid), 32'd0);
        chk("async_rst_addr", imem_addr, 32'h0);
        chk("async_rst_ifid_valid", 32'(if_id_valid), 32'd0);
        chk("async_rst_ifid_instr", if_id_instr, 32'h0);
        chk("async_rst_ifid_pc4", if_id_pc_plus_4, 32'h0);
        tick();
        at_neg();
        reset_n = 1'b1;
        stall_id = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = 32'h5555_AAAA;
        tick();
        imem_rsp_valid = 1'b0;
        at_neg();
        chk("stray_rsp_ifid_valid", 32'(if_id_valid), 32'd0);
        chk("restart_req_valid", 32'(imem_req_valid), 32'd1);
        chk("restart_addr", imem_addr, 32'h0);
        fetch(32'h0, 32'h0000_0020);
        tick();
        at_neg();

        chk("req_queue_drained", 32'(exp_req.size()), 32'd0);
        chk("ifid_queue_drained", 32'(exp_ifid.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
